// File: rtl/singleport_ctrl.sv
// singleport_ctrl: request-side controller for the 8x16 single-port RAM.
// It queues read/write requests, sequences them onto the shared RAM bus
// with an idle turnaround cycle after every access, and can sweep the RAM
// to zero after reset.
module singleport_ctrl #(
  parameter int DW             = 16,
  parameter int AW             = 3,
  parameter int QDEPTH         = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_done,
  output logic          init_done,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;
  localparam logic [CW-1:0] QFULL     = CW'(QDEPTH);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {CLR, IDLE, WR, RD} state_t;

  state_t        state_reg, state_next;
  logic [EW-1:0] fifo_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push, pop;
  logic          head_wr;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;
  logic [AW-1:0] clr_cnt_reg;
  logic          clr_stay;
  logic          ram_we_reg, ram_re_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          rsp_valid_reg, wr_done_reg, init_done_reg;
  logic [DW-1:0] rsp_rdata_reg;

  // Ready depends on the registered count only, so a pop never frees a slot early.
  assign req_ready = !rst && (count_reg < QFULL);
  assign push      = req_valid && req_ready;
  assign {head_wr, head_addr, head_wdata} = fifo_mem[rd_ptr_reg];

  // Queue storage: written on accept, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {req_wr, req_addr, req_wdata};
  end

  // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Next-state decode; the sweep ends once the last address has been on the bus.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      CLR: begin
        if (ram_we_reg && (ram_addr_reg == LAST_ADDR)) state_next = IDLE;
      end
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = head_wr ? WR : RD;
        end
      end
      WR:      state_next = IDLE;
      RD:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign clr_stay = (state_reg == CLR) && (state_next == CLR);

  // State register; reset restarts the sweep (or goes straight to IDLE).
  always_ff @(posedge clk) begin
    if (rst) state_reg <= CLEAR_ON_RESET ? CLR : IDLE;
    else     state_reg <= state_next;
  end

  // Registered bus controls and response strobes, loaded for the upcoming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_reg    <= 1'b0;
      ram_re_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      wdata_reg     <= '0;
      clr_cnt_reg   <= '0;
      wr_done_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      ram_we_reg    <= clr_stay || (state_next == WR);
      ram_re_reg    <= (state_next == RD);
      if (clr_stay) begin
        ram_addr_reg <= clr_cnt_reg;
        wdata_reg    <= '0;
        if (clr_cnt_reg != LAST_ADDR) clr_cnt_reg <= clr_cnt_reg + AW'(1);
      end else if (pop) begin
        ram_addr_reg <= head_addr;
        wdata_reg    <= head_wdata;
      end
      wr_done_reg   <= (state_reg == WR);
      rsp_valid_reg <= (state_reg == RD);
      if (state_reg == RD) rsp_rdata_reg <= ram_data;
      if (state_next != CLR) init_done_reg <= 1'b1;
    end
  end

  // Drive the bus only for writes; reads and idle leave it to the RAM.
  assign ram_data  = (ram_we_reg && !ram_re_reg) ? wdata_reg : {DW{1'bz}};
  assign ram_we    = ram_we_reg;
  assign ram_re    = ram_re_reg;
  assign ram_addr  = ram_addr_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign wr_done   = wr_done_reg;
  assign init_done = init_done_reg;

endmodule
